// File: rtl/pixel_stream_packer.sv
// Raster-order pixel packer: gathers PIXELS_PER_BEAT colour samples into a beat,
// tags it with lane-0 coordinates and frame/line markers, and buffers two beats.
module pixel_stream_packer #(
  parameter int unsigned COLOUR_W        = 24,
  parameter int unsigned SCREEN_WIDTH    = 640,
  parameter int unsigned SCREEN_HEIGHT   = 480,
  parameter int unsigned PIXELS_PER_BEAT = 1,
  parameter int unsigned COORD_W         = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [COLOUR_W-1:0]                 in_colour,
  input  logic                                in_valid,
  output logic                                in_ready,
  output logic [PIXELS_PER_BEAT*COLOUR_W-1:0] out_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [COORD_W-1:0]                  out_x,
  output logic [COORD_W-1:0]                  out_y,
  output logic                                out_sof,
  output logic                                out_eol,
  output logic                                frame_done
);

  localparam int unsigned BEAT_W = PIXELS_PER_BEAT * COLOUR_W;
  localparam int unsigned LANE_W = (PIXELS_PER_BEAT > 1) ? $clog2(PIXELS_PER_BEAT) : 1;
  localparam logic [LANE_W-1:0]  LAST_LANE = LANE_W'(PIXELS_PER_BEAT - 1);
  localparam logic [COORD_W-1:0] LAST_X    = COORD_W'(SCREEN_WIDTH - 1);
  localparam logic [COORD_W-1:0] LAST_Y    = COORD_W'(SCREEN_HEIGHT - 1);

  logic [LANE_W-1:0]  lane_q;
  logic [COORD_W-1:0] x_q;
  logic [COORD_W-1:0] y_q;
  logic [BEAT_W-1:0]  pack_q;

  logic [BEAT_W-1:0]  data_mem [2];
  logic [COORD_W-1:0] x_mem    [2];
  logic [COORD_W-1:0] y_mem    [2];
  logic               sof_mem  [2];
  logic               eol_mem  [2];
  logic               wr_ptr;
  logic               rd_ptr;
  logic [1:0]         count_q;

  logic               complete_c;
  logic               accept_c;
  logic               push_c;
  logic               pop_c;
  logic [BEAT_W-1:0]  beat_c;
  logic [COORD_W-1:0] beat_x_c;
  logic               beat_sof_c;
  logic               beat_eol_c;

  // Handshake decode: a completing pixel needs a free FIFO slot, others only fill the packer.
  always_comb begin
    complete_c = (lane_q == LAST_LANE);
    in_ready   = !reset && ((count_q != 2'd2) || !complete_c);
    accept_c   = in_valid && in_ready;
    push_c     = accept_c && complete_c;
    out_valid  = (count_q != 2'd0);
    pop_c      = out_valid && out_ready;
  end

  // Beat assembly: current pixel merged into the partial beat at its lane.
  always_comb begin
    beat_c = pack_q;
    for (int unsigned l = 0; l < PIXELS_PER_BEAT; l++) begin
      if (lane_q == LANE_W'(l)) begin
        beat_c[l*COLOUR_W +: COLOUR_W] = in_colour;
      end
    end
    // Beats never straddle a line, so lane 0 sits lane_q pixels to the left.
    beat_x_c   = x_q - COORD_W'(lane_q);
    beat_sof_c = (beat_x_c == '0) && (y_q == '0);
    beat_eol_c = (x_q == LAST_X);
  end

  always_comb begin
    out_data = data_mem[rd_ptr];
    out_x    = x_mem[rd_ptr];
    out_y    = y_mem[rd_ptr];
    out_sof  = sof_mem[rd_ptr];
    out_eol  = eol_mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lane_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      pack_q     <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      count_q    <= 2'd0;
      frame_done <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        data_mem[i] <= '0;
        x_mem[i]    <= '0;
        y_mem[i]    <= '0;
        sof_mem[i]  <= 1'b0;
        eol_mem[i]  <= 1'b0;
      end
    end else begin
      if (accept_c) begin
        pack_q <= beat_c;
        lane_q <= complete_c ? '0 : lane_q + LANE_W'(1);
        if (x_q == LAST_X) begin
          x_q <= '0;
          y_q <= (y_q == LAST_Y) ? '0 : y_q + COORD_W'(1);
        end else begin
          x_q <= x_q + COORD_W'(1);
        end
      end

      if (push_c) begin
        data_mem[wr_ptr] <= beat_c;
        x_mem[wr_ptr]    <= beat_x_c;
        y_mem[wr_ptr]    <= y_q;
        sof_mem[wr_ptr]  <= beat_sof_c;
        eol_mem[wr_ptr]  <= beat_eol_c;
        wr_ptr           <= ~wr_ptr;
      end

      if (pop_c) begin
        rd_ptr <= ~rd_ptr;
      end

      case ({push_c, pop_c})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase

      frame_done <= pop_c && out_eol && (out_y == LAST_Y);
    end
  end

endmodule

// File: doc/pixel_stream_packer.md
# pixel_stream_packer

Raster-order pixel stream generator that packs colour samples from the pixel calculation pipeline into multi-pixel beats, tags each beat with screen coordinates and frame/line markers, and drives the video output interface with a full valid/ready handshake. It replaces the single-pixel coordinate combinator: width, height, colour depth and pixels-per-beat are parameters, backpressure is absorbed by a 2-entry output buffer, and end of frame is signalled explicitly. It sits between the per-pixel colour generator (upstream) and the video DMA/stream interface (downstream).

## Interface
- COLOUR_W, 24, bits per pixel colour sample
- SCREEN_WIDTH, 640, pixels per line; must be a multiple of PIXELS_PER_BEAT
- SCREEN_HEIGHT, 480, lines per frame
- PIXELS_PER_BEAT, 1, pixels packed per output beat; legal values 1, 2, 4
- COORD_W, 16, coordinate width; must hold SCREEN_WIDTH-1 and SCREEN_HEIGHT-1

- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- in_colour  in  COLOUR_W  colour of the next pixel in raster order
- in_valid  in  1  in_colour is valid
- in_ready  out  1  block accepts a pixel this cycle
- out_data  out  PIXELS_PER_BEAT*COLOUR_W  packed beat; lane 0 (lowest x) in bits [COLOUR_W-1:0]
- out_valid  out  1  beat on out_* is valid
- out_ready  in  1  downstream accepts the beat
- out_x  out  COORD_W  x coordinate of lane 0 of the beat
- out_y  out  COORD_W  line of the beat
- out_sof  out  1  beat is first of frame (x=0, y=0)
- out_eol  out  1  beat contains pixel x=SCREEN_WIDTH-1
- frame_done  out  1  one-cycle pulse when the last beat of a frame is transferred

## Operation
- Input transfer: in_valid && in_ready. Output transfer: out_valid && out_ready.
- Lane counter (0..PIXELS_PER_BEAT-1) selects the lane written by each accepted pixel; partial beat held in a packing register.
- Pixel x/y counters advance on each input transfer: x increments by 1; at x=SCREEN_WIDTH-1 x wraps to 0 and y increments; at y=SCREEN_HEIGHT-1 with x wrapping, y wraps to 0 (next frame begins immediately, no gap).
- When the pixel filling lane PIXELS_PER_BEAT-1 is accepted, the complete beat plus lane-0 x, y, sof, eol is pushed into a 2-entry FIFO; head of FIFO drives out_*.
- in_ready = 1 when FIFO count < 2, or when the accepted pixel would not complete a beat (lane < PIXELS_PER_BEAT-1); forced 0 during reset.
- Push and pop in the same cycle with count=2 is not possible (in_ready=0 for completing pixel); with count=1 both occur and count stays 1.
- frame_done asserts the cycle after an output transfer of a beat with out_eol=1 and out_y=SCREEN_HEIGHT-1.
- Reset mid-frame: discards partial beat and FIFO contents; next accepted pixel is (0,0) and its beat carries out_sof=1.
- Unused lanes never exist (SCREEN_WIDTH multiple of PIXELS_PER_BEAT); no partial beats at line end.

## Timing
- Reset values: out_valid=0, out_data=0, out_x=0, out_y=0, out_sof=0, out_eol=0, frame_done=0, in_ready=0 while reset high, 1 the first cycle after.
- Latency: beat-completing pixel accepted at edge N -> out_valid=1 from cycle N+1 when FIFO was empty.
- Throughput: one pixel per cycle sustained while out_ready=1; no bubbles at line or frame boundaries.
- While out_valid=1 and out_ready=0, out_data/out_x/out_y/out_sof/out_eol hold stable.
- out_valid never deasserts without an output transfer (except reset).
- Coordinates are plain binary, zero-extended to COORD_W.

## Test plan
- PPB=1, 4x2 frame, in_valid=1, out_ready=1: 8 beats, out_x 0,1,2,3,0,1,2,3, out_y 0,0,0,0,1,1,1,1; sof on beat 0 only; eol on beats 3 and 7; frame_done pulse one cycle after beat 7; beat 8 is (0,0) with sof.
- PPB=4, 8x2 frame, colours 0x000001..0x000010: 4 beats; beat 0 out_data = {0x000004,0x000003,0x000002,0x000001}, out_x=0; beat 1 out_x=4, eol=1.
- Backpressure: PPB=1, out_ready=0 for 5 cycles: exactly 2 pixels accepted then in_ready=0; out_data stable; on out_ready=1 beats emerge in order with no loss or duplication.
- Random in_valid/out_ready (50%) over 3 full 640x480 frames: scoreboard matches every pixel colour and coordinate; frame_done count = 3.
- Reset asserted mid-line at (37,5) with FIFO holding 2 beats: out_valid=0 next cycle; first beat after reset is x=0, y=0, sof=1.
- Simultaneous push/pop at count=1: PPB=2, out_ready toggling each cycle: FIFO never exceeds 2, in_ready drops only on beat-completing pixels when full.
